hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes the per-instruction control fields produced at decode: rs1/rs2/rd addresses, rd_wren, is_load, branch/jump.
- Keeps its own registered shadow copy of the EX/MEM/WB occupancy.
- Drives the stall, flush and operand-forwarding selects, and counts stall and flush cycles for performance debug.

Parameters:
- FWD_EN, 1, 1 enables EX operand forwarding from MEM/WB; 0 resolves every RAW hazard by stalling.
- RF_WT, 1, 1 means the regfile is write-through (WB write visible to the same-cycle ID read); 0 means a WB-stage producer also stalls ID.
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1_addr  in  5  ID source 1
- id_rs2_addr  in  5  ID source 2
- id_rs1_used  in  1  ID reads rs1
- id_rs2_used  in  1  ID reads rs2
- id_rd_addr  in  5  ID destination
- id_rd_wren  in  1  ID writes the regfile
- id_is_load  in  1  ID is a load
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle
- lsu_busy  in  1  LSU not ready; freeze whole pipe
- stall_pc  out  1  hold PC
- stall_id  out  1  hold IF/ID
- flush_id  out  1  bubble into IF/ID
- flush_ex  out  1  bubble into ID/EX
- fwd_a_sel  out  2  EX operand A: 0 regfile, 1 MEM ALU result, 2 WB data
- fwd_b_sel  out  2  EX operand B, same encoding
- stall_cnt  out  CNT_W  cycles with stall_pc=1
- flush_cnt  out  CNT_W  cycles with ex_redirect=1

Behaviour:
- Shadow state: per stage EX/MEM/WB, registers valid, rd_addr, rd_wren, is_load; EX also holds rs1_addr/rs2_addr and their used flags. A producer is "live" iff valid & rd_wren & rd_addr!=0.
- Reset (i_rst at posedge): all shadow valids 0, counters 0. Outputs are therefore stall/flush 0 and fwd sels 0 in the cycle after reset. i_rst mid-operation discards all in-flight shadow state.
- Outputs are combinational from the shadow state plus current inputs (zero latency). Shadow state updates at posedge.
- Priority (highest first):
  1. Freeze, lsu_busy=1: stall_pc=stall_id=1, flush_id=flush_ex=0, shadow state holds, stall_cnt++. Forwarding selects still computed.
  2. Redirect, ex_redirect=1: flush_id=flush_ex=1, stall_pc=stall_id=0. This overrides any load-use/RAW stall because ID is wrong-path. EX→MEM→WB advances; EX shadow loads a bubble. flush_cnt++.
  3. Load-use: id_valid & EX live & ex_is_load & ((id_rs1_used & id_rs1_addr==ex_rd) | (id_rs2_used & id_rs2_addr==ex_rd)). Result: stall_pc=stall_id=1, flush_ex=1, EX shadow loads a bubble, MEM/WB advance, stall_cnt++. Exactly one stall cycle; the consumer then forwards from WB.
  4. FWD_EN=0 only: any id source matching a live EX or MEM producer stalls as in 3. A live WB producer also stalls when RF_WT=0.
  5. Otherwise: advance. EX shadow takes the ID fields qualified by id_valid.
- Forwarding (FWD_EN=1), per operand, for EX used sources:
  - sel=1 if MEM live & !mem_is_load & mem_rd==ex_rs.
  - Else sel=2 if WB live & wb_rd==ex_rs.
  - Else 0.
  - MEM has priority over WB. Source x0 never forwards. Unused sources give 0.
  - FWD_EN=0 forces sels to 0.
- Counters saturate at all-ones; no wrap.
- lsu_busy together with ex_redirect: freeze wins. The redirect is re-presented by EX next cycle because EX is held.

Test Plan:
- Forwarding: add x5 (EX) then sub x6,x5,x7 (ID). Next cycle fwd_a_sel=1, fwd_b_sel=0, no stall. One cycle later, with an unrelated instruction in between, fwd_a_sel=2.
- Load-use: lw x5 in EX, ID add x6,x0,x5 with rs2 used. Response: stall_pc=stall_id=flush_ex=1 for exactly 1 cycle, then fwd_b_sel=2, stall_cnt=1.
- x0 and priority: producer rd=x0 never stalls or forwards. MEM and WB both writing x9 with EX reading x9 gives sel=1.
- Redirect during load-use: both conditions in the same cycle give flush_id=flush_ex=1, stall_pc=0, flush_cnt=1, stall_cnt=0.
- Freeze: lsu_busy high for 3 cycles with the load-use condition present gives stall outputs for 3 cycles, no flush, shadow unchanged, stall_cnt=3. Then the load-use stall still occurs once (stall_cnt=4).
- Reset mid-stream: i_rst asserted during a load-use stall. Next cycle all outputs 0, counters 0. FWD_EN=0 build: add x5 then add x6,x5,x5 gives a 2-cycle stall.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage hazard fields toward the controller,
// stall/flush/forward controls and perf counters back to the core.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       id_rd_addr;
   logic             id_rd_wren;
   logic             id_is_load;
   logic             ex_redirect;
   logic             lsu_busy;
   logic             stall_pc;
   logic             stall_id;
   logic             flush_id;
   logic             flush_ex;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr,
      output id_rs1_used, id_rs2_used,
      output id_rd_addr, id_rd_wren, id_is_load,
      output ex_redirect, lsu_busy,
      input  stall_pc, stall_id, flush_id, flush_ex,
      input  fwd_a_sel, fwd_b_sel,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr,
      input  id_rs1_used, id_rs2_used,
      input  id_rd_addr, id_rd_wren, id_is_load,
      input  ex_redirect, lsu_busy,
      output stall_pc, stall_id, flush_id, flush_ex,
      output fwd_a_sel, fwd_b_sel,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage RV32I pipe,
// tracking EX/MEM/WB producers in a private shadow pipeline.
module hazard_ctrl #(
   parameter bit FWD_EN = 1'b1,
   parameter bit RF_WT  = 1'b1,
   parameter int CNT_W  = 32
) (
   input logic          i_clk,
   input logic          i_rst,
   hazard_ctrl_if.slave hz
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wren;
      logic       is_load;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_used;
      logic       rs2_used;
   } ex_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wren;
      logic       is_load;
   } mem_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wren;
   } wb_t;

   typedef enum logic [1:0] {
      M_ADV,
      M_STALL,
      M_REDIR,
      M_FREEZE
   } mode_e;

   ex_t              ex_q;
   ex_t              ex_d;
   mem_t             mem_q;
   wb_t              wb_q;
   logic             ex_live;
   logic             mem_live;
   logic             wb_live;
   logic             rd_ex;
   logic             rd_mem;
   logic             rd_wb;
   logic             load_use;
   logic             raw_stall;
   mode_e            mode;
   logic             stall_pc;
   logic             stall_id;
   logic             flush_id;
   logic             flush_ex;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   function automatic logic reads(
      input logic       v,
      input logic       u1,
      input logic [4:0] a1,
      input logic       u2,
      input logic [4:0] a2,
      input logic [4:0] r
   );
      return v & ((u1 & (a1 == r)) | (u2 & (a2 == r)));
   endfunction

   function automatic logic [1:0] fwd_sel(
      input logic       used,
      input logic [4:0] rs,
      input mem_t       m,
      input logic       m_live,
      input wb_t        w,
      input logic       w_live
   );
      logic [1:0] s;
      s = 2'd0;
      if (FWD_EN && used) begin
         if (m_live && !m.is_load && (m.rd == rs))
            s = 2'd1;
         else if (w_live && (w.rd == rs))
            s = 2'd2;
      end
      return s;
   endfunction

   assign ex_live  = ex_q.valid & ex_q.wren
                   & (ex_q.rd != 5'd0);
   assign mem_live = mem_q.valid & mem_q.wren
                   & (mem_q.rd != 5'd0);
   assign wb_live  = wb_q.valid & wb_q.wren
                   & (wb_q.rd != 5'd0);

   assign rd_ex  = reads(hz.id_valid,
                         hz.id_rs1_used, hz.id_rs1_addr,
                         hz.id_rs2_used, hz.id_rs2_addr,
                         ex_q.rd);
   assign rd_mem = reads(hz.id_valid,
                         hz.id_rs1_used, hz.id_rs1_addr,
                         hz.id_rs2_used, hz.id_rs2_addr,
                         mem_q.rd);
   assign rd_wb  = reads(hz.id_valid,
                         hz.id_rs1_used, hz.id_rs1_addr,
                         hz.id_rs2_used, hz.id_rs2_addr,
                         wb_q.rd);

   assign load_use  = ex_live & ex_q.is_load & rd_ex;
   assign raw_stall = !FWD_EN
                    & ((ex_live & rd_ex)
                     | (mem_live & rd_mem)
                     | (!RF_WT & wb_live & rd_wb));

   // pick the pipeline action for this cycle, highest priority first
   always_comb begin
      mode = M_ADV;
      if (hz.lsu_busy)
         mode = M_FREEZE;
      else if (hz.ex_redirect)
         mode = M_REDIR;
      else if (load_use | raw_stall)
         mode = M_STALL;
   end

   // decode the action into stall/flush strobes and operand selects
   always_comb begin
      stall_pc = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      fwd_a    = fwd_sel(ex_q.rs1_used, ex_q.rs1,
                         mem_q, mem_live, wb_q, wb_live);
      fwd_b    = fwd_sel(ex_q.rs2_used, ex_q.rs2,
                         mem_q, mem_live, wb_q, wb_live);
      unique case (mode)
         M_FREEZE: begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
         end
         M_REDIR: begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
         end
         M_STALL: begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
         end
         default: ;
      endcase
   end

   // ID fields as they would enter EX; a non-instruction is a bubble
   always_comb begin
      ex_d = '0;
      if (hz.id_valid) begin
         ex_d.valid    = 1'b1;
         ex_d.rd       = hz.id_rd_addr;
         ex_d.wren     = hz.id_rd_wren;
         ex_d.is_load  = hz.id_is_load;
         ex_d.rs1      = hz.id_rs1_addr;
         ex_d.rs2      = hz.id_rs2_addr;
         ex_d.rs1_used = hz.id_rs1_used;
         ex_d.rs2_used = hz.id_rs2_used;
      end
   end

   // shadow pipeline: hold on freeze, else shift with ID or a bubble
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (mode != M_FREEZE) begin
         wb_q.valid    <= mem_q.valid;
         wb_q.rd       <= mem_q.rd;
         wb_q.wren     <= mem_q.wren;
         mem_q.valid   <= ex_q.valid;
         mem_q.rd      <= ex_q.rd;
         mem_q.wren    <= ex_q.wren;
         mem_q.is_load <= ex_q.is_load;
         ex_q          <= (mode == M_ADV) ? ex_d : '0;
      end
   end

   // saturating perf counters for stall and redirect cycles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_pc && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if ((mode == M_REDIR) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign hz.stall_pc  = stall_pc;
   assign hz.stall_id  = stall_id;
   assign hz.flush_id  = flush_id;
   assign hz.flush_ex  = flush_ex;
   assign hz.fwd_a_sel = fwd_a;
   assign hz.fwd_b_sel = fwd_b;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench, instruction-level pipe model
// driving a forwarding build and a stall-only build in lockstep.
module tb_hazard_ctrl;

   localparam int CW   = 4;
   localparam int CMAX = 15;

   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
      int rs1;
      bit u1;
      int rs2;
      bit u2;
   } ins_t;

   typedef struct {
      bit spc;
      bit sid;
      bit fid;
      bit fex;
      int fa;
      int fb;
      int sc;
      int fc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       v_i;
   logic [4:0] rs1_i;
   logic [4:0] rs2_i;
   logic       u1_i;
   logic       u2_i;
   logic [4:0] rd_i;
   logic       wr_i;
   logic       ld_i;
   logic       redir_i;
   logic       busy_i;

   int tests;
   int fails;

   ins_t pipe [2][3];
   int   scnt [2];
   int   fcnt [2];
   exp_t q0 [$];
   exp_t q1 [$];

   hazard_ctrl_if #(.CNT_W(CW)) bus0 ();
   hazard_ctrl_if #(.CNT_W(CW)) bus1 ();

   assign bus0.id_valid    = v_i;
   assign bus0.id_rs1_addr = rs1_i;
   assign bus0.id_rs2_addr = rs2_i;
   assign bus0.id_rs1_used = u1_i;
   assign bus0.id_rs2_used = u2_i;
   assign bus0.id_rd_addr  = rd_i;
   assign bus0.id_rd_wren  = wr_i;
   assign bus0.id_is_load  = ld_i;
   assign bus0.ex_redirect = redir_i;
   assign bus0.lsu_busy    = busy_i;
   assign bus1.id_valid    = v_i;
   assign bus1.id_rs1_addr = rs1_i;
   assign bus1.id_rs2_addr = rs2_i;
   assign bus1.id_rs1_used = u1_i;
   assign bus1.id_rs2_used = u2_i;
   assign bus1.id_rd_addr  = rd_i;
   assign bus1.id_rd_wren  = wr_i;
   assign bus1.id_is_load  = ld_i;
   assign bus1.ex_redirect = redir_i;
   assign bus1.lsu_busy    = busy_i;

   hazard_ctrl #(
      .FWD_EN(1'b1),
      .RF_WT (1'b1),
      .CNT_W (CW)
   ) dut0 (
      .i_clk(clk),
      .i_rst(rst),
      .hz   (bus0.slave)
   );

   hazard_ctrl #(
      .FWD_EN(1'b0),
      .RF_WT (1'b1),
      .CNT_W (CW)
   ) dut1 (
      .i_clk(clk),
      .i_rst(rst),
      .hz   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ins_t mk(
      bit v, int rd, bit wr, bit ld,
      int rs1, bit u1, int rs2, bit u2
   );
      ins_t i;
      i.v   = v;
      i.rd  = rd;
      i.wr  = wr;
      i.ld  = ld;
      i.rs1 = rs1;
      i.u1  = u1;
      i.rs2 = rs2;
      i.u2  = u2;
      return i;
   endfunction

   function automatic bit live(ins_t i);
      return i.v && i.wr && (i.rd != 0);
   endfunction

   function automatic bit reads(ins_t id, int r);
      return id.v && ((id.u1 && id.rs1 == r)
                   || (id.u2 && id.rs2 == r));
   endfunction

   function automatic int fsel(
      bit fwd, bit u, int rs, ins_t m, ins_t w
   );
      if (!fwd || !u) return 0;
      if (live(m) && !m.ld && m.rd == rs) return 1;
      if (live(w) && w.rd == rs) return 2;
      return 0;
   endfunction

   task automatic cmp(string n, int got, int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s got %0d exp %0d", n, got, want);
      end
   endtask

   task automatic model_reset();
      ins_t b;
      b = mk(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 3; s++) pipe[k][s] = b;
         scnt[k] = 0;
         fcnt[k] = 0;
      end
   endtask

   task automatic model(
      int k, bit fwd, bit rfwt,
      ins_t c, bit redir, bit busy
   );
      ins_t ex, mem, wb, bub;
      exp_t e;
      bit   hzd;
      bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
      ex  = pipe[k][0];
      mem = pipe[k][1];
      wb  = pipe[k][2];
      hzd = (live(ex) && ex.ld && reads(c, ex.rd))
         || (!fwd && ((live(ex) && reads(c, ex.rd))
                   || (live(mem) && reads(c, mem.rd))
                   || (!rfwt && live(wb)
                       && reads(c, wb.rd))));
      e = '{default: 0};
      e.sc = scnt[k];
      e.fc = fcnt[k];
      e.fa = fsel(fwd, ex.u1, ex.rs1, mem, wb);
      e.fb = fsel(fwd, ex.u2, ex.rs2, mem, wb);
      if (busy) begin
         e.spc = 1;
         e.sid = 1;
         if (scnt[k] < CMAX) scnt[k]++;
      end else begin
         if (redir) begin
            e.fid = 1;
            e.fex = 1;
            if (fcnt[k] < CMAX) fcnt[k]++;
         end else if (hzd) begin
            e.spc = 1;
            e.sid = 1;
            e.fex = 1;
            if (scnt[k] < CMAX) scnt[k]++;
         end
         pipe[k][2] = mem;
         pipe[k][1] = ex;
         pipe[k][0] = (!redir && !hzd && c.v) ? c : bub;
      end
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic step(ins_t c, bit redir, bit busy, bit r);
      @(posedge clk);
      #1;
      rst     = r;
      v_i     = c.v;
      rd_i    = 5'(c.rd);
      wr_i    = c.wr;
      ld_i    = c.ld;
      rs1_i   = 5'(c.rs1);
      u1_i    = c.u1;
      rs2_i   = 5'(c.rs2);
      u2_i    = c.u2;
      redir_i = redir;
      busy_i  = busy;
      if (r) begin
         model_reset();
      end else begin
         model(0, 1'b1, 1'b1, c, redir, busy);
         model(1, 1'b0, 1'b1, c, redir, busy);
      end
   endtask

   task automatic chk(
      string t, exp_t e,
      int spc, int sid, int fid, int fex,
      int fa, int fb, int sc, int fc
   );
      cmp({t, ".stall_pc"}, spc, e.spc);
      cmp({t, ".stall_id"}, sid, e.sid);
      cmp({t, ".flush_id"}, fid, e.fid);
      cmp({t, ".flush_ex"}, fex, e.fex);
      cmp({t, ".fwd_a"}, fa, e.fa);
      cmp({t, ".fwd_b"}, fb, e.fb);
      cmp({t, ".stall_cnt"}, sc, e.sc);
      cmp({t, ".flush_cnt"}, fc, e.fc);
   endtask

   // monitor: pop one expectation per DUT per cycle
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("sb0", e,
                bus0.stall_pc, bus0.stall_id,
                bus0.flush_id, bus0.flush_ex,
                bus0.fwd_a_sel, bus0.fwd_b_sel,
                bus0.stall_cnt, bus0.flush_cnt);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("sb1", e,
                bus1.stall_pc, bus1.stall_id,
                bus1.flush_id, bus1.flush_ex,
                bus1.fwd_a_sel, bus1.fwd_b_sel,
                bus1.stall_cnt, bus1.flush_cnt);
         end
      end
   end

   initial begin : stim
      ins_t nop, add5, sub6, unrel, use5a, lw5;
      ins_t use5b, lw0, rd0, addi9, use9, add655;
      ins_t c;
      tests = 0;
      fails = 0;
      rst = 1'b1;
      v_i = 0; rs1_i = 0; rs2_i = 0;
      u1_i = 0; u2_i = 0; rd_i = 0;
      wr_i = 0; ld_i = 0;
      redir_i = 0; busy_i = 0;
      model_reset();

      nop    = mk(0, 0, 0, 0, 0, 0, 0, 0);
      add5   = mk(1, 5, 1, 0, 1, 1, 2, 1);
      sub6   = mk(1, 6, 1, 0, 5, 1, 7, 1);
      unrel  = mk(1, 10, 1, 0, 11, 1, 0, 0);
      use5a  = mk(1, 12, 1, 0, 5, 1, 0, 0);
      lw5    = mk(1, 5, 1, 1, 1, 1, 0, 0);
      use5b  = mk(1, 6, 1, 0, 0, 1, 5, 1);
      lw0    = mk(1, 0, 1, 1, 1, 1, 0, 0);
      rd0    = mk(1, 13, 1, 0, 0, 1, 0, 1);
      addi9  = mk(1, 9, 1, 0, 1, 1, 0, 0);
      use9   = mk(1, 14, 1, 0, 9, 1, 9, 1);
      add655 = mk(1, 6, 1, 0, 5, 1, 5, 1);

      step(nop, 0, 0, 1);
      step(nop, 0, 0, 1);
      @(negedge clk);
      cmp("rst.stall_pc", bus0.stall_pc, 0);
      cmp("rst.stall_cnt", bus0.stall_cnt, 0);

      // forward from MEM
      step(add5, 0, 0, 0);
      step(sub6, 0, 0, 0);
      step(nop, 0, 0, 0);
      @(negedge clk);
      cmp("fwd_mem.a", bus0.fwd_a_sel, 1);
      cmp("fwd_mem.b", bus0.fwd_b_sel, 0);
      cmp("fwd_mem.stall", bus0.stall_pc, 0);

      // forward from WB
      step(add5, 0, 0, 0);
      step(unrel, 0, 0, 0);
      step(use5a, 0, 0, 0);
      step(nop, 0, 0, 0);
      @(negedge clk);
      cmp("fwd_wb.a", bus0.fwd_a_sel, 2);

      // load-use
      step(nop, 0, 0, 1);
      step(lw5, 0, 0, 0);
      step(use5b, 0, 0, 0);
      @(negedge clk);
      cmp("lu.stall_pc", bus0.stall_pc, 1);
      cmp("lu.stall_id", bus0.stall_id, 1);
      cmp("lu.flush_ex", bus0.flush_ex, 1);
      cmp("lu.flush_id", bus0.flush_id, 0);
      step(use5b, 0, 0, 0);
      @(negedge clk);
      cmp("lu.once", bus0.stall_pc, 0);
      step(nop, 0, 0, 0);
      @(negedge clk);
      cmp("lu.fwd_b", bus0.fwd_b_sel, 2);
      cmp("lu.fwd_a", bus0.fwd_a_sel, 0);
      cmp("lu.cnt", bus0.stall_cnt, 1);

      // x0 never a producer, MEM beats WB
      step(nop, 0, 0, 1);
      step(lw0, 0, 0, 0);
      step(rd0, 0, 0, 0);
      @(negedge clk);
      cmp("x0.stall0", bus0.stall_pc, 0);
      cmp("x0.stall1", bus1.stall_pc, 0);
      step(nop, 0, 0, 0);
      @(negedge clk);
      cmp("x0.fwd_a", bus0.fwd_a_sel, 0);
      cmp("x0.fwd_b", bus0.fwd_b_sel, 0);
      step(addi9, 0, 0, 0);
      step(addi9, 0, 0, 0);
      step(use9, 0, 0, 0);
      @(negedge clk);
      cmp("prio.stall", bus0.stall_pc, 0);
      step(nop, 0, 0, 0);
      @(negedge clk);
      cmp("prio.fwd_a", bus0.fwd_a_sel, 1);
      cmp("prio.fwd_b", bus0.fwd_b_sel, 1);

      // redirect beats load-use
      step(nop, 0, 0, 1);
      step(lw5, 0, 0, 0);
      step(use5b, 1, 0, 0);
      @(negedge clk);
      cmp("redir.flush_id", bus0.flush_id, 1);
      cmp("redir.flush_ex", bus0.flush_ex, 1);
      cmp("redir.stall_pc", bus0.stall_pc, 0);
      cmp("redir.stall_id", bus0.stall_id, 0);
      step(nop, 0, 0, 0);
      @(negedge clk);
      cmp("redir.flush_cnt", bus0.flush_cnt, 1);
      cmp("redir.stall_cnt", bus0.stall_cnt, 0);

      // freeze over a pending load-use
      step(nop, 0, 0, 1);
      step(lw5, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(use5b, 0, 1, 0);
         @(negedge clk);
         cmp("frz.stall_pc", bus0.stall_pc, 1);
         cmp("frz.flush_ex", bus0.flush_ex, 0);
      end
      step(use5b, 0, 0, 0);
      @(negedge clk);
      cmp("frz.lu_stall", bus0.stall_pc, 1);
      cmp("frz.lu_flush", bus0.flush_ex, 1);
      cmp("frz.cnt3", bus0.stall_cnt, 3);
      step(use5b, 0, 0, 0);
      @(negedge clk);
      cmp("frz.done", bus0.stall_pc, 0);
      cmp("frz.cnt4", bus0.stall_cnt, 4);
      step(nop, 1, 1, 0);
      @(negedge clk);
      cmp("frz_redir.stall", bus0.stall_pc, 1);
      cmp("frz_redir.flush", bus0.flush_id, 0);

      // reset during a load-use stall
      step(nop, 0, 0, 1);
      step(lw5, 0, 0, 0);
      step(use5b, 0, 0, 1);
      step(use5b, 0, 0, 0);
      @(negedge clk);
      cmp("mrst.stall_pc", bus0.stall_pc, 0);
      cmp("mrst.flush_ex", bus0.flush_ex, 0);
      cmp("mrst.stall_cnt", bus0.stall_cnt, 0);
      cmp("mrst.flush_cnt", bus0.flush_cnt, 0);

      // stall-only build: two-cycle RAW stall
      step(nop, 0, 0, 1);
      step(add5, 0, 0, 0);
      step(add655, 0, 0, 0);
      @(negedge clk);
      cmp("nofwd.c1", bus1.stall_pc, 1);
      cmp("fwd.nostall", bus0.stall_pc, 0);
      step(add655, 0, 0, 0);
      @(negedge clk);
      cmp("nofwd.c2", bus1.stall_pc, 1);
      step(add655, 0, 0, 0);
      @(negedge clk);
      cmp("nofwd.c3", bus1.stall_pc, 0);
      cmp("nofwd.cnt", bus1.stall_cnt, 2);

      // counter saturation
      step(nop, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(nop, 0, 1, 0);
      step(nop, 0, 0, 0);
      @(negedge clk);
      cmp("sat.cnt0", bus0.stall_cnt, CMAX);
      cmp("sat.cnt1", bus1.stall_cnt, CMAX);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         c = mk($urandom_range(0, 3) != 0,
                $urandom_range(0, 7),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 7),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 7),
                $urandom_range(0, 1) == 1);
         step(c,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 99) == 0);
      end

      step(nop, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      cmp("sb.drain", q0.size() + q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule
